// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two requesters (fetch, load/store), the arbiter
// and the single-port memory. The arbiter uses the slave modport; the
// requester/memory side uses the master modport.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    // Instruction-fetch port
    logic              if_req;
    logic              if_we;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_wdata;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    // Memory command / response
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_we, if_addr, if_wdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_we, mem_re, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_we, if_addr, if_wdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port memory.
// Each granted request takes four cycles: IDLE -> ACCESS -> WAIT -> DONE.
// All outputs come straight from registers.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    localparam logic PortIf = 1'b0;
    localparam logic PortDm = 1'b1;

    state_e            state_q;
    logic              sel_q;
    logic              last_q;
    logic              op_we_q;   // remembers read/write after mem_we/mem_re drop
    logic              mem_we_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              busy_q;

    logic              any_req;
    logic              grant_dm;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // Pick the winner: on contention the port that did not win last time.
    always_comb begin
        any_req  = bus.if_req | bus.dm_req;
        grant_dm = 1'b0;
        if (bus.if_req && bus.dm_req) begin
            grant_dm = (last_q == PortIf);
        end else begin
            grant_dm = bus.dm_req;
        end
        g_we    = grant_dm ? bus.dm_we    : bus.if_we;
        g_addr  = grant_dm ? bus.dm_addr  : bus.if_addr;
        g_wdata = grant_dm ? bus.dm_wdata : bus.if_wdata;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= PortIf;
            last_q      <= PortDm;
            op_we_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q     <= StAccess;
                        busy_q      <= 1'b1;
                        sel_q       <= grant_dm;
                        last_q      <= grant_dm;
                        op_we_q     <= g_we;
                        mem_we_q    <= g_we;
                        mem_re_q    <= ~g_we;
                        mem_addr_q  <= g_addr;
                        mem_wdata_q <= g_wdata;
                    end
                end
                StAccess: begin
                    // Memory executes the command on this edge.
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    if (sel_q == PortDm) begin
                        dm_ack_q <= 1'b1;
                        if (!op_we_q) dm_rdata_q <= bus.mem_rdata;
                    end else begin
                        if_ack_q <= 1'b1;
                        if (!op_we_q) if_rdata_q <= bus.mem_rdata;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 16x8 memory, scoreboard queue of
// expected transactions in service order, and a negedge monitor.
module tb_mem_arbiter;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam logic PortIf = 1'b0;
    localparam logic PortDm = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory with registered read port.
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;

    // Push in the order the arbiter is expected to serve requests.
    task automatic expect_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        txn_t t;
        t.port = port;
        t.we   = we;
        t.addr = addr;
        if (we) begin
            ref_mem[addr] = wdata;
            t.data = wdata;
        end else begin
            t.data = ref_mem[addr];
        end
        exp_q.push_back(t);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    int ack_cyc[$];
    logic cmd_prev = 1'b0;
    logic if_ack_prev = 1'b0;
    logic dm_ack_prev = 1'b0;
    logic [DW-1:0] if_rd_prev = '0;
    logic [DW-1:0] dm_rd_prev = '0;

    // Monitor: memory commands and acks against the scoreboard head.
    always @(negedge clk) begin
        if (bus.mem_we || bus.mem_re) begin
            check_eq("cmd_exclusive", 32'(bus.mem_we & bus.mem_re), 32'd0);
            check_eq("cmd_width", 32'(cmd_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("cmd_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("cmd_we", 32'(bus.mem_we), 32'(exp_q[0].we));
                check_eq("cmd_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
                if (exp_q[0].we) check_eq("cmd_wdata", 32'(bus.mem_wdata), 32'(exp_q[0].data));
            end
        end
        if (bus.if_ack || bus.dm_ack) begin
            ack_cyc.push_back(cyc);
            check_eq("ack_exclusive", 32'(bus.if_ack & bus.dm_ack), 32'd0);
            check_eq("ack_width",
                     32'((bus.if_ack & if_ack_prev) | (bus.dm_ack & dm_ack_prev)), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", 32'd1, 32'd0);
            end else begin
                mon_t = exp_q.pop_front();
                check_eq("ack_port", 32'(bus.dm_ack), 32'(mon_t.port));
                if (mon_t.port == PortDm) begin
                    check_eq("idle_if_rdata", 32'(bus.if_rdata), 32'(if_rd_prev));
                    if (mon_t.we) check_eq("wr_dm_rdata_held", 32'(bus.dm_rdata), 32'(dm_rd_prev));
                    else          check_eq("rd_dm_rdata", 32'(bus.dm_rdata), 32'(mon_t.data));
                end else begin
                    check_eq("idle_dm_rdata", 32'(bus.dm_rdata), 32'(dm_rd_prev));
                    if (mon_t.we) check_eq("wr_if_rdata_held", 32'(bus.if_rdata), 32'(if_rd_prev));
                    else          check_eq("rd_if_rdata", 32'(bus.if_rdata), 32'(mon_t.data));
                end
            end
        end
        cmd_prev    <= bus.mem_we | bus.mem_re;
        if_ack_prev <= bus.if_ack;
        dm_ack_prev <= bus.dm_ack;
        if_rd_prev  <= bus.if_rdata;
        dm_rd_prev  <= bus.dm_rdata;
    end

    task automatic drive_port(input logic port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        if (port == PortDm) begin
            bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata; bus.dm_req = 1'b1;
        end else begin
            bus.if_we = we; bus.if_addr = addr; bus.if_wdata = wdata; bus.if_req = 1'b1;
        end
    endtask

    // Requester: call just after a posedge; returns the posedge count until ack.
    task automatic do_req(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        drive_port(port, we, addr, wdata);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = (port == PortDm) ? bus.dm_ack : bus.if_ack;
        end
        if (!seen) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("busy_at_ack", 32'(bus.busy), 32'd1);
        end
        @(posedge clk);
        #1;
        if (seen) check_eq("busy_after_done", 32'(bus.busy), 32'd0);
        if (port == PortDm) bus.dm_req = 1'b0;
        else                bus.if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    int lat_a, lat_b;
    logic seen_r;

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_we = 1'b0; bus.if_addr = '0; bus.if_wdata = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = DW'(8'hA0 + i);
            ref_mem[i] = DW'(8'hA0 + i);
        end
        mem[6]     = 8'h10;
        ref_mem[6] = 8'h10;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_if_ack",    32'(bus.if_ack),    32'd0);
        check_eq("rst_dm_ack",    32'(bus.dm_ack),    32'd0);
        check_eq("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check_eq("rst_mem_re",    32'(bus.mem_re),    32'd0);
        check_eq("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst_if_rdata",  32'(bus.if_rdata),  32'd0);
        check_eq("rst_dm_rdata",  32'(bus.dm_rdata),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Contention right after reset: fetch wins, then load/store.
        expect_txn(PortIf, 1'b0, 4'd6, 8'h00);
        expect_txn(PortDm, 1'b1, 4'd6, 8'h61);
        fork
            do_req(PortIf, 1'b0, 4'd6, 8'h00, lat_a);
            do_req(PortDm, 1'b1, 4'd6, 8'h61, lat_b);
        join
        check_eq("cont_if_lat", 32'(lat_a), 32'd3);
        check_eq("cont_dm_lat", 32'(lat_b), 32'd7);
        expect_txn(PortIf, 1'b0, 4'd6, 8'h00);
        do_req(PortIf, 1'b0, 4'd6, 8'h00, lat_a);
        check_eq("reread_lat", 32'(lat_a), 32'd3);

        // Write then read on the load/store port.
        expect_txn(PortDm, 1'b1, 4'd7, 8'h15);
        do_req(PortDm, 1'b1, 4'd7, 8'h15, lat_a);
        check_eq("wr_lat", 32'(lat_a), 32'd3);
        expect_txn(PortDm, 1'b0, 4'd7, 8'h00);
        do_req(PortDm, 1'b0, 4'd7, 8'h00, lat_a);
        check_eq("rd_lat", 32'(lat_a), 32'd3);

        // Fairness: both ports keep requesting for four transactions.
        expect_txn(PortIf, 1'b0, 4'd1, 8'h00);
        expect_txn(PortDm, 1'b0, 4'd2, 8'h00);
        expect_txn(PortIf, 1'b0, 4'd3, 8'h00);
        expect_txn(PortDm, 1'b0, 4'd4, 8'h00);
        ack_cyc.delete();
        fork
            begin
                do_req(PortIf, 1'b0, 4'd1, 8'h00, lat_a);
                do_req(PortIf, 1'b0, 4'd3, 8'h00, lat_a);
            end
            begin
                do_req(PortDm, 1'b0, 4'd2, 8'h00, lat_b);
                do_req(PortDm, 1'b0, 4'd4, 8'h00, lat_b);
            end
        join
        check_eq("fair_ack_count", 32'(ack_cyc.size()), 32'd4);
        if (ack_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) begin
                check_eq("fair_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
            end
        end

        // Write isolation: restore dm_rdata to 0x15, then dm writes 15 while if reads 0.
        expect_txn(PortDm, 1'b0, 4'd7, 8'h00);
        do_req(PortDm, 1'b0, 4'd7, 8'h00, lat_a);
        expect_txn(PortDm, 1'b1, 4'd15, 8'h61);
        expect_txn(PortIf, 1'b0, 4'd0, 8'h00);
        fork
            do_req(PortDm, 1'b1, 4'd15, 8'h61, lat_a);
            begin
                @(posedge clk);
                #1;
                do_req(PortIf, 1'b0, 4'd0, 8'h00, lat_b);
            end
        join
        check_eq("iso_dm_rdata", 32'(bus.dm_rdata), 32'h15);
        check_eq("iso_if_rdata", 32'(bus.if_rdata), 32'h0A0);

        // Reset in WAIT during a dm read; the request is re-served after release.
        expect_txn(PortDm, 1'b0, 4'd7, 8'h00);
        drive_port(PortDm, 1'b0, 4'd7, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_busy",     32'(bus.busy),     32'd0);
        check_eq("midrst_mem_re",   32'(bus.mem_re),   32'd0);
        check_eq("midrst_if_ack",   32'(bus.if_ack),   32'd0);
        check_eq("midrst_dm_ack",   32'(bus.dm_ack),   32'd0);
        check_eq("midrst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_no_ack", 32'(bus.dm_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_r = 1'b0;
        lat_a  = 0;
        for (int i = 0; i < 40 && !seen_r; i++) begin
            @(posedge clk);
            lat_a++;
            @(negedge clk);
            seen_r = bus.dm_ack;
        end
        check_eq("midrst_retry_lat", 32'(lat_a), 32'd3);
        @(posedge clk);
        #1;
        bus.dm_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
